// File: rtl/lsu.sv
// Load/store unit: turns one decoded load or store into a single bus
// transaction and returns a completion pulse with an optional load result.
//
// Parameters
//   TIMEOUT      cycles mem_req_o may be held without mem_ack_i (1..255)
//
// Ports
//   clk_i        clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset
//   ls_i         load/store request from the decoder, sampled only in idle
//   mem_read_i   load select
//   mem_write_i  store select
//   funct3_i     access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr_i       effective byte address
//   wdata_i      store data
//   rd_i         load destination register
//   mem_req_o    bus request, held until ack or timeout
//   mem_we_o     bus write enable
//   mem_addr_o   word-aligned bus address
//   mem_be_o     bus byte enables
//   mem_wdata_o  lane-replicated store data
//   mem_ack_i    bus completion, mem_rdata_i valid in the same cycle
//   mem_rdata_i  bus read word
//   busy_o       high while a transaction is in flight or completing
//   done_o       one-cycle completion pulse
//   err_o        with done_o: misaligned, illegal or timed out
//   reg_write_o  with done_o: successful load, write rd_o
//   rd_o         latched destination register
//   rdata_o      extended load result, held after done_o
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ls_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        reg_write_o,
  output logic [4:0]  rd_o,
  output logic [31:0] rdata_o
);

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_t;

  // Count value on the last permitted un-acked request cycle.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic [2:0]  f3;
  logic [1:0]  ofs;

  logic        illegal;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] rshift;
  logic [31:0] load_ext;

  // Request decode, evaluated on the incoming decoder fields.
  always_comb begin
    illegal = (mem_read_i == mem_write_i);
    if (mem_write_i) begin
      if (funct3_i != 3'b000 && funct3_i != 3'b001 && funct3_i != 3'b010) illegal = 1'b1;
    end else begin
      if (funct3_i == 3'b011 || funct3_i == 3'b110 || funct3_i == 3'b111) illegal = 1'b1;
    end

    misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                 ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));

    be_next    = 4'b1111;
    wdata_next = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_next    = 4'b0001 << addr_i[1:0];
        wdata_next = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_next    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{wdata_i[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = wdata_i;
      end
    endcase
  end

  // Load result: move the addressed lane down to bit 0, then extend.
  always_comb begin
    rshift   = mem_rdata_i >> {ofs, 3'b000};
    load_ext = rshift;
    case (f3)
      3'b000:  load_ext = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_ext = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  load_ext = {24'h000000, rshift[7:0]};
      3'b101:  load_ext = {16'h0000, rshift[15:0]};
      default: load_ext = rshift;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= StIdle;
      tmo_cnt     <= 8'd0;
      f3          <= 3'd0;
      ofs         <= 2'd0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'd0;
      mem_be_o    <= 4'd0;
      mem_wdata_o <= 32'd0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      reg_write_o <= 1'b0;
      rd_o        <= 5'd0;
      rdata_o     <= 32'd0;
    end else begin
      // Completion flags are pulses; only the transitions below raise them.
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      reg_write_o <= 1'b0;

      case (state)
        StIdle: begin
          if (ls_i) begin
            f3          <= funct3_i;
            ofs         <= addr_i[1:0];
            rd_o        <= rd_i;
            mem_we_o    <= mem_write_i;
            mem_addr_o  <= {addr_i[31:2], 2'b00};
            mem_be_o    <= be_next;
            mem_wdata_o <= wdata_next;
            tmo_cnt     <= 8'd0;
            busy_o      <= 1'b1;
            if (illegal || misaligned) begin
              // Rejected without touching the bus.
              state  <= StDone;
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end else begin
              state     <= StBus;
              mem_req_o <= 1'b1;
            end
          end
        end

        StBus: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (mem_ack_i) begin
            state     <= StDone;
            mem_req_o <= 1'b0;
            done_o    <= 1'b1;
            if (!mem_we_o) begin
              reg_write_o <= 1'b1;
              rdata_o     <= load_ext;
            end
          end else if (tmo_cnt == TimeoutLast) begin
            state     <= StDone;
            mem_req_o <= 1'b0;
            done_o    <= 1'b1;
            err_o     <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        StDone: begin
          state  <= StIdle;
          busy_o <= 1'b0;
        end

        default: begin
          state     <= StIdle;
          mem_req_o <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum number of cycles mem_req_o is held without mem_ack_i (legal range 1..255).
REQ-002 SHALL have one clock and a synchronous, active-high reset, with ports listed as follows.
REQ-003 clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 ls_i  input  1  decoder load/store request, sampled only in IDLE.
REQ-006 mem_read_i / mem_write_i  input  1 each  decoder load / store select.
REQ-007 funct3_i  input  3  access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 addr_i  input  32  effective byte address (ALU result).
REQ-009 wdata_i  input  32  store data (rs2 value).
REQ-010 rd_i  input  5  load destination register.
REQ-011 mem_req_o  output  1  bus request, held until ack or timeout.
REQ-012 mem_we_o  output  1  1 = write.
REQ-013 mem_addr_o  output  32  word-aligned address, {addr_i[31:2],2'b00}.
REQ-014 mem_be_o  output  4  byte enables.
REQ-015 mem_wdata_o  output  32  lane-replicated store data.
REQ-016 mem_ack_i  input  1  bus completion; mem_rdata_i is valid in the same cycle.
REQ-017 mem_rdata_i  input  32  read word.
REQ-018 busy_o  output  1  high in BUS and DONE.
REQ-019 done_o  output  1  one-cycle completion pulse.
REQ-020 err_o  output  1  qualifies done_o: misaligned access, illegal access, or timeout.
REQ-021 reg_write_o  output  1  high with done_o for a successful load.
REQ-022 rd_o  output  5  latched rd_i.
REQ-023 rdata_o  output  32  extended load result, valid while done_o is high.

Function
REQ-024 SHALL implement the FSM IDLE -> BUS -> DONE -> IDLE, or IDLE -> DONE -> IDLE on error; all outputs are registered.
REQ-025 SHALL, in IDLE with ls_i=1, latch addr_i, wdata_i, funct3_i, rd_i and the direction; ls_i is ignored in every other state.
REQ-026 SHALL treat as illegal: mem_read_i equal to mem_write_i; a store funct3 not in {000,001,010}; a load funct3 not in {000,001,010,100,101}.
REQ-027 SHALL treat as misaligned: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0.
REQ-028 SHALL, on an illegal or misaligned request, go to DONE without asserting mem_req_o; done_o=1 and err_o=1 in the cycle after acceptance.
REQ-029 SHALL, on a legal request, assert mem_req_o in the cycle after acceptance, with mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o stable until the request drops.
REQ-030 Byte enables SHALL be: B 0001<<addr[1:0]; H 0011 if addr[1]=0, else 1100; W 1111. This applies to loads and stores.
REQ-031 Store data SHALL be: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-032 SHALL, for a load, shift mem_rdata_i right by 8*addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU) into rdata_o.
REQ-033 SHALL, on mem_ack_i=1 in BUS, drop mem_req_o, enter DONE, and pulse done_o in the next cycle; reg_write_o=1 only for a load. Latency = acceptance + 1 + ack wait + 1.
REQ-034 SHALL ignore mem_ack_i outside BUS.
REQ-035 SHALL count the cycles mem_req_o is high without ack; after TIMEOUT such cycles, drop mem_req_o, enter DONE, and assert err_o=1 and reg_write_o=0.
REQ-036 Ack in the same cycle as the TIMEOUT-th count SHALL complete normally, with no error.
REQ-037 SHALL hold rdata_o and rd_o after done_o; err_o and reg_write_o are high only with done_o.
REQ-038 A new request SHALL be accepted no earlier than the cycle after DONE, which gives back-to-back throughput of one access per 3 + ack-wait cycles.

Reset
REQ-039 SHALL, on rst_i=1 at a clock edge, go to IDLE and clear every output and the timeout counter to 0, including mid-transaction.
REQ-040 SHALL not issue a pending request after reset; the bus master must tolerate a request withdrawn by reset.

Verification
REQ-041 SW, addr 0x100, wdata 0xDEADBEEF, ack 2 cycles after req -> mem_be_o=1111, mem_addr_o=0x100, done_o one cycle after ack, reg_write_o=0.
REQ-042 LB addr 0x103, mem_rdata_i 0x80123456 -> rdata_o 0xFFFFFF80, reg_write_o=1; LBU with the same inputs -> 0x00000080.
REQ-043 SH addr 0x102, wdata 0x0000ABCD -> mem_be_o=1100, mem_wdata_o=0xABCDABCD; LH addr 0x102 with rdata 0x8001xxxx -> rdata_o 0xFFFF8001.
REQ-044 LW addr 0x102, or mem_read_i=mem_write_i=1 -> mem_req_o never asserted; done_o=err_o=1 in the cycle after ls_i.
REQ-045 TIMEOUT=4, no ack -> mem_req_o high exactly 4 cycles, then done_o=err_o=1; ack on the 4th cycle instead -> no error.
REQ-046 rst_i pulsed while in BUS -> mem_req_o=0 and busy_o=0 next cycle; ls_i pulsed while busy is ignored; a late ack in IDLE causes no done_o.
